// File: rtl/vme_ram_readout_if.sv
// vme_ram_readout_if
//   Groups the signals between the monitor-RAM readout block and its
//   surroundings: the snooped writer strobe/address and spill gate, the RAM
//   read port, and the VME-side request/data/status lines.
//
//   slave  : the readout block itself (vme_ram_readout).
//   master : the environment (writer, RAM, VME register interface).
//
//   Signals:
//     LIVE        spill gate
//     wr_ena      writer write strobe (snooped)
//     wr_addr     writer address (snooped)
//     rd_req      VME read request
//     rd_en       RAM read enable, one-cycle pulse
//     rd_addr     RAM read address
//     rd_data     RAM read data
//     dout        last word read, held until the next capture
//     dout_valid  one-cycle pulse marking a new dout
//     words_avail entries written in the last spill
//     busy        readout in progress
//     done        all entries delivered, or none written
//     aborted     sticky: LIVE rose before readout finished
interface vme_ram_readout_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              LIVE;
  logic              wr_ena;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_req;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [ADDR_W-1:0] words_avail;
  logic              busy;
  logic              done;
  logic              aborted;

  modport slave (
    input  LIVE, wr_ena, wr_addr, rd_req, rd_data,
    output rd_en, rd_addr, dout, dout_valid, words_avail, busy, done, aborted
  );

  modport master (
    output LIVE, wr_ena, wr_addr, rd_req, rd_data,
    input  rd_en, rd_addr, dout, dout_valid, words_avail, busy, done, aborted
  );
endinterface

// File: rtl/vme_ram_readout.sv
// vme_ram_readout
//   Reads back the monitor RAM filled during a LIVE spill. While LIVE is
//   high the writer's wr_ena/wr_addr are snooped to learn how many entries
//   were written; after LIVE falls, entries 1..words_avail are served one
//   per VME read request, then done is raised. A LIVE rise at any time
//   restarts capture and marks an unfinished readout as aborted.
//
//   Parameters:
//     ADDR_W  RAM address width
//     DATA_W  RAM data width
//     RD_LAT  edges from the RAM sampling rd_en to the edge on which
//             rd_data is sampled (1..7)
//
//   Ports:
//     clk    system clock (shared with writer and RAM)
//     reset  asynchronous, active-low reset
//     bus    vme_ram_readout_if.slave (see interface for signal list)
//
//   All outputs are registered.
module vme_ram_readout #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  vme_ram_readout_if.slave      bus
);

  typedef enum logic [1:0] {
    S_CAPTURE = 2'd0,
    S_READY   = 2'd1,
    S_FETCH   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t            state, state_n;

  logic              live_d;
  logic [ADDR_W-1:0] words_avail_q, words_avail_n;
  logic [ADDR_W-1:0] next_addr, next_addr_n;
  logic              rd_en_q, rd_en_n;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_n;
  logic [DATA_W-1:0] dout_q, dout_n;
  logic              dout_valid_q, dout_valid_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              aborted_q, aborted_n;
  logic [2:0]        lat_cnt, lat_cnt_n;

  logic              rise, fall;
  logic [ADDR_W-1:0] words_eff;

  assign rise = bus.LIVE & ~live_d;
  assign fall = ~bus.LIVE & live_d;

  // A write strobe on the falling edge still counts, so the empty-spill
  // decision uses the count including that write.
  assign words_eff = bus.wr_ena ? bus.wr_addr : words_avail_q;

  always_comb begin
    state_n       = state;
    words_avail_n = words_avail_q;
    next_addr_n   = next_addr;
    rd_en_n       = 1'b0;
    rd_addr_n     = rd_addr_q;
    dout_n        = dout_q;
    dout_valid_n  = 1'b0;
    aborted_n     = aborted_q;
    lat_cnt_n     = lat_cnt;

    if (rise) begin
      // Rise wins over everything, including a coincident data sample.
      state_n       = S_CAPTURE;
      words_avail_n = '0;
      next_addr_n   = '0;
      aborted_n     = (state == S_READY) || (state == S_FETCH);
    end else begin
      unique case (state)
        S_CAPTURE: begin
          words_avail_n = words_eff;
          if (fall) begin
            if (words_eff == '0) begin
              state_n = S_DONE;
            end else begin
              state_n     = S_READY;
              next_addr_n = ADDR_W'(1);
            end
          end
        end
        S_READY: begin
          if (bus.rd_req) begin
            rd_addr_n = next_addr;
            rd_en_n   = 1'b1;
            lat_cnt_n = '0;
            state_n   = S_FETCH;
          end
        end
        S_FETCH: begin
          // lat_cnt counts edges after the request edge; the RAM samples
          // on the first of them, data is valid RD_LAT edges later.
          if (lat_cnt == LAT) begin
            dout_n       = bus.rd_data;
            dout_valid_n = 1'b1;
            if (next_addr == words_avail_q) begin
              state_n = S_DONE;
            end else begin
              next_addr_n = next_addr + 1'b1;
              state_n     = S_READY;
            end
          end else begin
            lat_cnt_n = lat_cnt + 1'b1;
          end
        end
        S_DONE: begin
        end
        default: state_n = S_CAPTURE;
      endcase
    end

    busy_n = (state_n == S_READY) || (state_n == S_FETCH);
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_CAPTURE;
      live_d        <= 1'b0;
      words_avail_q <= '0;
      next_addr     <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      lat_cnt       <= '0;
    end else begin
      state         <= state_n;
      live_d        <= bus.LIVE;
      words_avail_q <= words_avail_n;
      next_addr     <= next_addr_n;
      rd_en_q       <= rd_en_n;
      rd_addr_q     <= rd_addr_n;
      dout_q        <= dout_n;
      dout_valid_q  <= dout_valid_n;
      busy_q        <= busy_n;
      done_q        <= done_n;
      aborted_q     <= aborted_n;
      lat_cnt       <= lat_cnt_n;
    end
  end

  assign bus.rd_en       = rd_en_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.words_avail = words_avail_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;

endmodule

// File: tb/tb_vme_ram_readout.sv
// tb_vme_ram_readout
//   Bench for vme_ram_readout: a per-cycle vector table of
//   {LIVE, wr_ena, wr_addr, rd_req} -> expected registered outputs, plus
//   hand-written sequences for asynchronous reset and a full 4095-entry
//   spill. The RAM model returns addr*0x11 exactly RD_LAT edges after it
//   samples rd_en and garbage otherwise.
module tb_vme_ram_readout;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  vme_ram_readout_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vme_ram_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM read port model, preloaded with addr*0x11.
  logic [DATA_W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe[0] <= bus.rd_en ? (32'(bus.rd_addr) * 32'h11) : (32'hBAD0_0000 ^ 32'(cyc));
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.rd_data = pipe[RD_LAT-1];

  typedef struct {
    logic        live;
    logic        we;
    logic [11:0] wa_in;
    logic        req;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [31:0] dout;
    logic        dv;
    logic [11:0] words;
    logic        busy;
    logic        done;
    logic        aborted;
  } vec_t;

  vec_t tbl[$];

  // Slow-changing expectations carried while the table is filled.
  logic [11:0] e_rd_addr = '0;
  logic [31:0] e_dout    = '0;
  logic [11:0] e_wa      = '0;
  logic        e_ab      = 1'b0;

  function automatic logic [60:0] outs();
    return {bus.rd_en, bus.rd_addr, bus.dout, bus.dout_valid,
            bus.words_avail, bus.busy, bus.done, bus.aborted};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic v(input logic live, input logic we, input int wa_in, input logic req,
                   input logic en, input logic dv, input logic busy, input logic done);
    vec_t t;
    t.live = live; t.we = we; t.wa_in = 12'(wa_in); t.req = req;
    t.rd_en = en; t.rd_addr = e_rd_addr; t.dout = e_dout; t.dv = dv;
    t.words = e_wa; t.busy = busy; t.done = done; t.aborted = e_ab;
    tbl.push_back(t);
  endtask

  task automatic rise_capture();
    e_wa = '0;
    v(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic write_words(input int n);
    for (int k = 1; k <= n; k++) begin
      e_wa = 12'(k);
      v(1, 1, k, 0, 0, 0, 0, 0);
    end
  endtask

  // One read: READY edge with request, then RD_LAT+1 FETCH edges.
  task automatic read_word(input int r, input logic last, input logic hold);
    e_rd_addr = 12'(r);
    v(0, 0, 0, 1, 1, 0, 1, 0);
    v(0, 0, 0, hold, 0, 0, 1, 0);
    v(0, 0, 0, hold, 0, 0, 1, 0);
    e_dout = 32'(r) * 32'h11;
    v(0, 0, 0, hold, 0, 1, !last, last);
  endtask

  initial begin
    int n, cnt, errs, exp_addr;
    logic [11:0] last_addr;

    bus.LIVE = 0; bus.wr_ena = 0; bus.wr_addr = '0; bus.rd_req = 0;

    // Basic 5-word spill; a request during FETCH of read 2 is ignored.
    e_ab = 0; rise_capture();
    write_words(5);
    v(0, 0, 0, 0, 0, 0, 1, 0);
    for (int r = 1; r <= 5; r++) read_word(r, r == 5, r == 2);
    v(0, 0, 0, 1, 0, 0, 0, 1);
    v(0, 1, 9, 1, 0, 0, 0, 1);
    // Empty spill: done straight after the fall, requests ignored.
    e_ab = 0; rise_capture();
    v(0, 0, 0, 0, 0, 0, 0, 1);
    v(0, 0, 0, 1, 0, 0, 0, 1);
    // Request held high: back-to-back reads, then ignored.
    e_ab = 0; rise_capture();
    write_words(3);
    v(0, 0, 0, 1, 0, 0, 1, 0);
    for (int r = 1; r <= 3; r++) read_word(r, r == 3, 1'b1);
    v(0, 0, 0, 1, 0, 0, 0, 1);
    v(0, 0, 0, 1, 0, 0, 0, 1);
    // Abort during FETCH of read 3, then a clean 3-word spill.
    e_ab = 0; rise_capture();
    write_words(5);
    v(0, 0, 0, 0, 0, 0, 1, 0);
    read_word(1, 0, 0);
    read_word(2, 0, 0);
    e_rd_addr = 12'd3;
    v(0, 0, 0, 1, 1, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 1, 0);
    e_ab = 1; rise_capture();
    v(1, 0, 0, 0, 0, 0, 0, 0);
    write_words(3);
    v(0, 0, 0, 0, 0, 0, 1, 0);
    for (int r = 1; r <= 3; r++) read_word(r, r == 3, 1'b0);
    e_ab = 0; rise_capture();
    // Rise on the data sample edge: rise wins, no dout_valid.
    write_words(2);
    v(0, 0, 0, 0, 0, 0, 1, 0);
    e_rd_addr = 12'd1;
    v(0, 0, 0, 1, 1, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 1, 0);
    e_ab = 1; rise_capture();
    v(0, 0, 0, 0, 0, 0, 0, 1);
    // Write strobe on the fall edge counts; abort from READY.
    e_ab = 0; rise_capture();
    write_words(1);
    e_wa = 12'd2;
    v(0, 1, 2, 0, 0, 0, 1, 0);
    e_ab = 1; rise_capture();
    v(0, 0, 0, 0, 0, 0, 0, 1);

    // Reset state.
    repeat (3) @(posedge clk);
    #1 chk("reset_state", outs(), '0);
    @(negedge clk) reset = 1;

    foreach (tbl[i]) begin
      bus.LIVE = tbl[i].live; bus.wr_ena = tbl[i].we;
      bus.wr_addr = tbl[i].wa_in; bus.rd_req = tbl[i].req;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].rd_en, tbl[i].rd_addr, tbl[i].dout, tbl[i].dv,
           tbl[i].words, tbl[i].busy, tbl[i].done, tbl[i].aborted});
    end
    bus.wr_ena = 0; bus.rd_req = 0;

    // Asynchronous reset mid-FETCH.
    bus.LIVE = 1; @(posedge clk); #1;
    bus.wr_ena = 1; bus.wr_addr = 12'd1; @(posedge clk); #1;
    bus.wr_addr = 12'd2; @(posedge clk); #1;
    bus.wr_ena = 0; bus.LIVE = 0; @(posedge clk); #1;
    bus.rd_req = 1; @(posedge clk); #1;
    bus.rd_req = 0; @(posedge clk); #1;
    chk("pre_reset_busy", {bus.busy, bus.words_avail}, {1'b1, 12'd2});
    #2 reset = 0;
    #1 chk("async_reset", outs(), '0);
    @(negedge clk) reset = 1;
    bus.rd_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_reset_idle", {bus.busy, bus.done, bus.rd_en, bus.dout_valid}, '0);
    bus.rd_req = 0; bus.LIVE = 1; @(posedge clk); #1;
    bus.wr_ena = 1; bus.wr_addr = 12'd1; @(posedge clk); #1;
    bus.wr_ena = 0; bus.LIVE = 0; @(posedge clk); #1;
    chk("one_word_ready", {bus.busy, bus.words_avail}, {1'b1, 12'd1});
    bus.rd_req = 1; @(posedge clk); #1;
    bus.rd_req = 0;
    n = 0;
    while (!bus.dout_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("one_word_latency", n, RD_LAT + 1);
    chk("one_word_data", {bus.dout, bus.done}, {32'h11, 1'b1});

    // Full 4095-entry spill with the request held high.
    bus.LIVE = 1; @(posedge clk); #1;
    bus.wr_ena = 1;
    for (int k = 1; k <= 4095; k++) begin
      bus.wr_addr = 12'(k); @(posedge clk); #1;
    end
    bus.wr_ena = 0; bus.LIVE = 0; @(posedge clk); #1;
    chk("big_words", {bus.busy, bus.words_avail}, {1'b1, 12'hFFF});
    bus.rd_req = 1;
    n = 0; cnt = 0; errs = 0; exp_addr = 1; last_addr = '0;
    while (!bus.done && n < 20000) begin
      @(posedge clk); #1; n++;
      if (bus.rd_en) begin
        if (32'(bus.rd_addr) != exp_addr) errs++;
        last_addr = bus.rd_addr;
        exp_addr++;
      end
      if (bus.dout_valid) begin
        cnt++;
        if (bus.dout != 32'(cnt) * 32'h11) errs++;
      end
    end
    chk("big_count", cnt, 4095);
    chk("big_last_addr", last_addr, 12'hFFF);
    chk("big_seq_errs", errs, 0);
    chk("big_done", {bus.done, bus.busy}, 2'b10);
    @(posedge clk); #1;
    chk("big_no_wrap", {bus.rd_en, bus.dout_valid, bus.dout}, {2'b00, 32'hFFF * 32'h11});
    bus.rd_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
